// File: rtl/eth_rx_frame_len_check.sv
// eth_rx_frame_len_check
// Single-region MFB stage that measures the byte length of each frame, flags
// undersize/oversize frames on the EOF word and forwards the stream through
// one registered stage with full backpressure.
// Optional statistics counters: define ETH_RX_FRAME_LEN_CHECK_STATS_EN.
module eth_rx_frame_len_check #(
  parameter int REGION_SIZE   = 8,
  parameter int BLOCK_SIZE    = 8,
  parameter int ITEM_WIDTH    = 8,
  parameter int RX_MTU        = 16383,
  parameter int MIN_FRAME_LEN = 64,
  parameter int CNT_WIDTH     = 64,
  localparam int WORD_BYTES   = REGION_SIZE * BLOCK_SIZE,
  localparam int DATA_W       = WORD_BYTES * ITEM_WIDTH,
  localparam int SOF_POS_W    = (REGION_SIZE > 1) ? $clog2(REGION_SIZE) : 1,
  localparam int EOF_POS_W    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [DATA_W-1:0]    RX_MFB_DATA,
  input  logic [SOF_POS_W-1:0] RX_MFB_SOF_POS,
  input  logic [EOF_POS_W-1:0] RX_MFB_EOF_POS,
  input  logic                 RX_MFB_SOF,
  input  logic                 RX_MFB_EOF,
  input  logic                 RX_MFB_SRC_RDY,
  output logic                 RX_MFB_DST_RDY,
  output logic [DATA_W-1:0]    TX_MFB_DATA,
  output logic [SOF_POS_W-1:0] TX_MFB_SOF_POS,
  output logic [EOF_POS_W-1:0] TX_MFB_EOF_POS,
  output logic                 TX_MFB_SOF,
  output logic                 TX_MFB_EOF,
  output logic                 TX_MFB_SRC_RDY,
  input  logic                 TX_MFB_DST_RDY,
  output logic                 TX_MFB_ERROR,
  output logic [15:0]          TX_MFB_LEN,
  input  logic                 CNT_CLEAR,
  output logic [CNT_WIDTH-1:0] CNT_GOOD,
  output logic [CNT_WIDTH-1:0] CNT_UNDERSIZE,
  output logic [CNT_WIDTH-1:0] CNT_OVERSIZE
);

  localparam logic [15:0] W16     = 16'(WORD_BYTES);
  localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME_LEN);
  localparam logic [15:0] MAX_LEN = 16'(RX_MTU);

  // Length arithmetic sticks at 16'hFFFF instead of wrapping, so a runaway
  // frame can never alias back into the legal range.
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  function automatic logic len_illegal(input logic [15:0] len);
    return (len < MIN_LEN) || (len > MAX_LEN);
  endfunction

  logic        vld_p1;
  logic        dst_rdy;
  logic        accept;
  logic        in_frame;
  logic [15:0] acc;
  logic [15:0] sof_byte;
  logic [15:0] eof_byte;
  logic [15:0] acc_nx;
  logic        in_frame_nx;
  logic [15:0] len_c;
  logic        eof_ok_c;
  logic        err_c;

  logic [DATA_W-1:0]    data_p1;
  logic [SOF_POS_W-1:0] sof_pos_p1;
  logic [EOF_POS_W-1:0] eof_pos_p1;
  logic                 sof_p1;
  logic                 eof_p1;
  logic                 err_p1;
  logic [15:0]          len_p1;

  assign dst_rdy  = TX_MFB_DST_RDY || !vld_p1;
  assign accept   = RX_MFB_SRC_RDY && dst_rdy;
  assign sof_byte = 16'(RX_MFB_SOF_POS) * 16'(BLOCK_SIZE);
  assign eof_byte = 16'(RX_MFB_EOF_POS);
  assign err_c    = eof_ok_c && len_illegal(len_c);

  // Per-word length bookkeeping: closes the running frame on EOF and (re)opens
  // one on SOF. An EOF that does not close a known frame yields no length.
  // A single-word frame arriving mid-frame also abandons the old frame.
  always_comb begin
    acc_nx      = acc;
    in_frame_nx = in_frame;
    len_c       = '0;
    eof_ok_c    = 1'b0;
    if (RX_MFB_SOF && RX_MFB_EOF && (sof_byte <= eof_byte)) begin
      len_c       = eof_byte - sof_byte + 16'd1;
      eof_ok_c    = 1'b1;
      in_frame_nx = 1'b0;
    end else begin
      if (RX_MFB_EOF && in_frame) begin
        len_c       = sat_add(acc, eof_byte + 16'd1);
        eof_ok_c    = 1'b1;
        in_frame_nx = 1'b0;
      end
      if (RX_MFB_SOF) begin
        acc_nx      = W16 - sof_byte;
        in_frame_nx = 1'b1;
      end else if (!RX_MFB_EOF && in_frame) begin
        acc_nx = sat_add(acc, W16);
      end
    end
  end

  // Frame state advances only on accepted words.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      in_frame <= 1'b0;
      acc      <= '0;
    end else if (accept) begin
      in_frame <= in_frame_nx;
      acc      <= acc_nx;
    end
  end

  // ---- stage p1: output register, holds while downstream stalls ----
  always_ff @(posedge CLK) begin
    if (RESET) begin
      vld_p1     <= 1'b0;
      data_p1    <= '0;
      sof_pos_p1 <= '0;
      eof_pos_p1 <= '0;
      sof_p1     <= 1'b0;
      eof_p1     <= 1'b0;
      err_p1     <= 1'b0;
      len_p1     <= '0;
    end else if (dst_rdy) begin
      vld_p1 <= RX_MFB_SRC_RDY;
      if (accept) begin
        data_p1    <= RX_MFB_DATA;
        sof_pos_p1 <= RX_MFB_SOF_POS;
        eof_pos_p1 <= RX_MFB_EOF_POS;
        sof_p1     <= RX_MFB_SOF;
        eof_p1     <= RX_MFB_EOF;
        err_p1     <= err_c;
        len_p1     <= len_c;
      end
    end
  end

  assign RX_MFB_DST_RDY = dst_rdy;
  assign TX_MFB_SRC_RDY = vld_p1;
  assign TX_MFB_DATA    = data_p1;
  assign TX_MFB_SOF_POS = sof_pos_p1;
  assign TX_MFB_EOF_POS = eof_pos_p1;
  assign TX_MFB_SOF     = sof_p1;
  assign TX_MFB_EOF     = eof_p1;
  assign TX_MFB_ERROR   = err_p1;
  assign TX_MFB_LEN     = len_p1;

`ifdef ETH_RX_FRAME_LEN_CHECK_STATS_EN
  logic [CNT_WIDTH-1:0] cnt_good_p1;
  logic [CNT_WIDTH-1:0] cnt_under_p1;
  logic [CNT_WIDTH-1:0] cnt_over_p1;

  // Classify each closed frame; clear has priority over a same-cycle count.
  always_ff @(posedge CLK) begin
    if (RESET || CNT_CLEAR) begin
      cnt_good_p1  <= '0;
      cnt_under_p1 <= '0;
      cnt_over_p1  <= '0;
    end else if (accept && eof_ok_c) begin
      if (len_c < MIN_LEN)      cnt_under_p1 <= cnt_under_p1 + 1'b1;
      else if (len_c > MAX_LEN) cnt_over_p1  <= cnt_over_p1 + 1'b1;
      else                      cnt_good_p1  <= cnt_good_p1 + 1'b1;
    end
  end

  assign CNT_GOOD      = cnt_good_p1;
  assign CNT_UNDERSIZE = cnt_under_p1;
  assign CNT_OVERSIZE  = cnt_over_p1;
`else
  logic unused_cnt_clear;
  assign unused_cnt_clear = CNT_CLEAR;
  assign CNT_GOOD         = '0;
  assign CNT_UNDERSIZE    = '0;
  assign CNT_OVERSIZE     = '0;
`endif

endmodule

// File: doc/eth_rx_frame_len_check.md
# eth_rx_frame_len_check

Single-region MFB stage between the Ethernet MAC RX output and the network module RX path. It measures the byte length of every frame passing through and flags frames shorter than MIN_FRAME_LEN or longer than RX_MTU on the EOF word. It forwards the stream through one registered pipeline stage with full backpressure. Optional per-port statistics counters count good, undersize and oversize frames.

## Interface
- REGION_SIZE, 8, blocks per word
- BLOCK_SIZE, 8, items per block
- ITEM_WIDTH, 8, bits per item (byte)
- RX_MTU, 16383, maximum legal frame length in bytes
- MIN_FRAME_LEN, 64, minimum legal frame length in bytes
- CNT_WIDTH, 64, statistics counter width
- CLK  in  1  sole clock
- RESET  in  1  synchronous, active-high reset
- RX_MFB_DATA  in  REGION_SIZE*BLOCK_SIZE*ITEM_WIDTH  input word (W = REGION_SIZE*BLOCK_SIZE bytes; 64 by default)
- RX_MFB_SOF_POS  in  log2(REGION_SIZE)  SOF block index
- RX_MFB_EOF_POS  in  log2(W)  EOF byte index
- RX_MFB_SOF, RX_MFB_EOF, RX_MFB_SRC_RDY  in  1 each
- RX_MFB_DST_RDY  out  1
- TX_MFB_DATA, TX_MFB_SOF_POS, TX_MFB_EOF_POS, TX_MFB_SOF, TX_MFB_EOF, TX_MFB_SRC_RDY  out  same widths as RX
- TX_MFB_DST_RDY  in  1
- TX_MFB_ERROR  out  1  frame ending in this word has an illegal length; valid only when TX_MFB_EOF=1
- TX_MFB_LEN  out  16  length of the frame ending in this word; valid only when TX_MFB_EOF=1
- CNT_CLEAR  in  1  clears statistics counters
- CNT_GOOD, CNT_UNDERSIZE, CNT_OVERSIZE  out  CNT_WIDTH each  statistics counters

## Operation
- Transfer rule: a word is accepted when RX_MFB_SRC_RDY & RX_MFB_DST_RDY.
- Ready rule: RX_MFB_DST_RDY = TX_MFB_DST_RDY | !TX_MFB_SRC_RDY.
- State: in_frame (1 bit) and acc (16-bit byte accumulator). Both are updated only on an accepted word.
- Per-word cases, with s = SOF_POS*BLOCK_SIZE and e = EOF_POS:
  - SOF only: acc = W - s; in_frame = 1.
  - Neither flag, in_frame=1: acc += W.
  - Neither flag, in_frame=0: no change (idle word).
  - EOF only, in_frame=1: len = acc + e + 1; in_frame = 0.
  - SOF and EOF with s <= e (single-word frame): len = e - s + 1; in_frame unchanged (stays 0).
  - SOF and EOF with s > e (end and start in one word): len = acc + e + 1; then acc = W - s; in_frame = 1.
- Accumulator arithmetic saturates at 16'hFFFF and never wraps.
- Length check at EOF: ERROR = (len < MIN_FRAME_LEN) | (len > RX_MTU).
- Protocol error, EOF with in_frame=0 and no preceding SOF in the word: word is forwarded, ERROR=0, LEN=0, no counter changes.
- Protocol error, SOF while in_frame=1 and no EOF in the word: the old frame is abandoned uncounted and acc restarts.
- Data, SOF/EOF flags and positions pass through unchanged. Frames are never dropped or truncated.

## Timing
- Latency: 1 cycle from RX accept to TX_MFB_SRC_RDY.
- The output register holds while TX_MFB_SRC_RDY & !TX_MFB_DST_RDY. TX outputs stay stable while stalled.
- Full throughput: one word per cycle when TX_MFB_DST_RDY=1.
- Reset values: all TX_* outputs 0, TX_MFB_SRC_RDY=0, in_frame=0, acc=0, counters 0. RX_MFB_DST_RDY=1 in the cycle after reset.
- Reset mid-frame discards the partial frame. The next word without SOF is treated as idle.
- Counters increment one cycle after the EOF word is accepted on RX.
- CNT_CLEAR wins over a simultaneous increment; the result is 0.

## Configuration
- ETH_RX_FRAME_LEN_CHECK_STATS_EN:
  - Defined: the three counters are implemented. They wrap modulo 2^CNT_WIDTH.
  - Not defined: counter registers are removed, CNT_* are tied to 0 and CNT_CLEAR is ignored. Datapath behaviour is identical either way.

## Test plan
- 64 B frame, SOF_POS=0, EOF_POS=63, one word -> TX one cycle later, LEN=64, ERROR=0, CNT_GOOD=1.
- 60 B frame in one word -> LEN=60, ERROR=1, CNT_UNDERSIZE=1.
- 16384 B frame over 256 words -> LEN=16384, ERROR=1, CNT_OVERSIZE=1. A 16383 B frame -> ERROR=0.
- Word with EOF_POS=15 ending a 144 B frame plus SOF_POS=4 -> LEN=144 flagged good. New frame acc=32; its next word with EOF_POS=31 gives LEN=64.
- Random TX_MFB_DST_RDY stalls on 1000 mixed frames (1..16400 B) -> output stream bit-identical to input, no loss or duplication, counters match the scoreboard.
- RESET asserted mid-frame, then CNT_CLEAR -> TX_MFB_SRC_RDY=0 after reset, partial frame uncounted, all counters 0.
